// File: rtl/qbus_pkg.sv
// Shared types and constants for the Qbus DMA bus-master sequencer.
package qbus_pkg;

   localparam int BDAL_W = 22;

   // Addresses with bits 21:13 all set fall in the IO page and need BBS7.
   localparam logic [BDAL_W-1:0] IO_PAGE_MASK = 22'o17760000;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_REQ,
      ST_ACK,
      ST_ADDR,
      ST_SYNC,
      ST_DATA,
      ST_WAIT_RPLY,
      ST_DESKEW,
      ST_NEG,
      ST_END,
      ST_REL
   } dma_state_t;

   // Gate drives to the open-drain Qbus control lines plus the BDAL gate enable.
   typedef struct packed {
      logic bdmr;
      logic bsack;
      logic bsync;
      logic bdin;
      logic bdout;
      logic bwtbt;
      logic bbs7;
      logic outbound;
   } drv_t;

   function automatic logic in_io_page(input logic [BDAL_W-1:0] addr);
      return (addr & IO_PAGE_MASK) == IO_PAGE_MASK;
   endfunction

endpackage

// File: rtl/qbus_sync.sv
// Multi-flop synchronizer for asynchronous Qbus receiver inputs.
// Resets to all ones, which is the negated level of the inverted receivers.
module qbus_sync #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage_q [STAGES];
   logic [WIDTH-1:0] stage_d [STAGES];

   // Shift each stage from its predecessor; stage 0 samples the raw input.
   always_comb begin
      stage_d[0] = d;
      for (int i = 1; i < STAGES; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   // Synchronizer flops, reset to the deasserted level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < STAGES; i++) begin
            stage_q[i] <= '1;
         end
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   assign q = stage_q[STAGES-1];

endmodule

// File: rtl/qbus_dma_master.sv
// Qbus DMA bus-master sequencer: arbitration, address phase, DATI/DATO data
// phases and bus release for a multi-word command from the host.
module qbus_dma_master
   import qbus_pkg::*;
#(
   parameter int SETUP_CYC   = 15,
   parameter int HOLD_CYC    = 10,
   parameter int DESKEW_CYC  = 5,
   parameter int TIMEOUT_CYC = 1000,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_start,
   input  logic              cmd_write,
   input  logic [21:0]       cmd_addr,
   input  logic [7:0]        cmd_count,
   input  logic              abort,
   input  logic [15:0]       wr_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   output logic [15:0]       rd_data,
   output logic              rd_valid,
   output logic              busy,
   output logic              done,
   output logic              err_timeout,
   output logic              err_init,
   input  logic [21:0]       bdal_in_f,
   input  logic              bsync_f,
   input  logic              brply_f,
   input  logic              bdmgi_f,
   input  logic              binit_f,
   output logic [21:0]       bdal_out,
   output logic [21:0]       bdal_oe,
   output logic              outbound,
   output logic              bdmr_g,
   output logic              bsack_g,
   output logic              bsync_g,
   output logic              bdin_g,
   output logic              bdout_g,
   output logic              bwtbt_g,
   output logic              bbs7_g
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] DESKEW_LAST  = CNT_W'(DESKEW_CYC - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   // Synchronized receivers (still inverted: 0 = line asserted).
   logic [BDAL_W+3:0] async_in;
   logic [BDAL_W+3:0] sync_out;
   logic [15:0]       bdal_s;
   logic              bsync_s, bdmgi_s, brply_s, binit_s;
   logic              unused_bits;

   assign async_in = {binit_f, brply_f, bdmgi_f, bsync_f, bdal_in_f};

   qbus_sync #(
      .WIDTH  (BDAL_W + 4),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (async_in),
      .q     (sync_out)
   );

   assign bdal_s      = sync_out[15:0];
   assign bsync_s     = sync_out[BDAL_W];
   assign bdmgi_s     = sync_out[BDAL_W+1];
   assign brply_s     = sync_out[BDAL_W+2];
   assign binit_s     = sync_out[BDAL_W+3];
   assign unused_bits = ^{sync_out[BDAL_W-1:16], cmd_addr[0]};

   dma_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [21:0]       addr_q, addr_d;
   logic [8:0]        words_q, words_d;
   logic              wr_q, wr_d;
   logic              abort_q, abort_d;
   logic [15:0]       wdata_q, wdata_d;
   drv_t              drv_q, drv_d;
   logic [21:0]       bdal_out_q, bdal_out_d;
   logic [21:0]       bdal_oe_q, bdal_oe_d;
   logic              wr_ready_q, wr_ready_d;
   logic [15:0]       rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_timeout_q, err_timeout_d;
   logic              err_init_q, err_init_d;
   logic              strobe_phase;

   // Sequencer next state plus decode of every registered bus drive from it.
   always_comb begin
      state_d       = state_q;
      cnt_d         = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      addr_d        = addr_q;
      words_d       = words_q;
      wr_d          = wr_q;
      abort_d       = abort_q | (abort && (state_q != ST_IDLE));
      wdata_d       = wdata_q;
      rd_data_d     = rd_data_q;
      rd_valid_d    = 1'b0;
      wr_ready_d    = 1'b0;
      done_d        = 1'b0;
      err_timeout_d = err_timeout_q;
      err_init_d    = err_init_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_start) begin
               addr_d        = {cmd_addr[21:1], 1'b0};
               wr_d          = cmd_write;
               words_d       = {(cmd_count == 8'd0), cmd_count};
               abort_d       = 1'b0;
               err_timeout_d = 1'b0;
               err_init_d    = 1'b0;
               state_d       = ST_REQ;
            end
         end
         ST_REQ: begin
            // Abort before the grant: the bus was never taken, just release.
            if (abort) begin
               state_d = ST_REL;
            end else if (!bdmgi_s && bsync_s && brply_s) begin
               state_d = ST_ACK;
            end
         end
         ST_ACK: state_d = ST_ADDR;
         ST_ADDR: begin
            if ((cnt_q >= SETUP_LAST) && (!wr_q || wr_valid)) begin
               state_d = ST_SYNC;
            end
         end
         ST_SYNC: begin
            if (cnt_q >= HOLD_LAST) begin
               state_d    = ST_DATA;
               wdata_d    = wr_data;
               wr_ready_d = wr_q;
            end
         end
         ST_DATA: begin
            if (!wr_q || (cnt_q >= SETUP_LAST)) begin
               state_d = ST_WAIT_RPLY;
            end
         end
         ST_WAIT_RPLY: begin
            // A reply seen in the timeout cycle still counts as a reply.
            if (!brply_s) begin
               state_d = ST_DESKEW;
            end else if (cnt_q >= TIMEOUT_LAST) begin
               err_timeout_d = 1'b1;
               state_d       = ST_NEG;
            end
         end
         ST_DESKEW: begin
            if (cnt_q >= DESKEW_LAST) begin
               state_d = ST_NEG;
               if (!wr_q) begin
                  rd_data_d  = ~bdal_s;
                  rd_valid_d = 1'b1;
               end
            end
         end
         ST_NEG: begin
            if ((!wr_q || (cnt_q >= HOLD_LAST)) && (err_timeout_q || brply_s)) begin
               state_d = ST_END;
            end
         end
         ST_END: begin
            if (cnt_q >= HOLD_LAST) begin
               if ((words_q > 9'd1) && !err_timeout_q && !abort_d) begin
                  addr_d  = addr_q + 22'd2;
                  words_d = words_q - 9'd1;
                  state_d = ST_ADDR;
               end else begin
                  state_d = ST_REL;
               end
            end
         end
         ST_REL: begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      // BINIT from the bus overrides everything: drop all drives at once.
      if ((state_q != ST_IDLE) && !binit_s) begin
         state_d    = ST_IDLE;
         err_init_d = 1'b1;
         done_d     = 1'b1;
         wr_ready_d = 1'b0;
         rd_valid_d = 1'b0;
      end

      if (state_d != state_q) begin
         cnt_d = '0;
      end

      drv_d        = '0;
      bdal_out_d   = '0;
      bdal_oe_d    = '0;
      strobe_phase = (state_d == ST_WAIT_RPLY) || (state_d == ST_DESKEW);
      case (state_d)
         ST_REQ: drv_d.bdmr = 1'b1;
         ST_ACK, ST_END: drv_d.bsack = 1'b1;
         ST_ADDR, ST_SYNC: begin
            drv_d.bsack    = 1'b1;
            drv_d.bsync    = (state_d == ST_SYNC);
            drv_d.outbound = 1'b1;
            drv_d.bwtbt    = wr_d;
            drv_d.bbs7     = in_io_page(addr_d);
            bdal_out_d     = addr_d;
            bdal_oe_d      = '1;
         end
         ST_DATA, ST_WAIT_RPLY, ST_DESKEW, ST_NEG: begin
            drv_d.bsack = 1'b1;
            drv_d.bsync = 1'b1;
            drv_d.bdin  = !wr_d && strobe_phase;
            drv_d.bdout = wr_d && strobe_phase;
            if (wr_d) begin
               drv_d.outbound = 1'b1;
               bdal_out_d     = {6'b0, wdata_d};
               bdal_oe_d      = '1;
            end
         end
         default: ;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State, datapath and registered outputs; reset leaves every bus line negated.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         addr_q        <= '0;
         words_q       <= '0;
         wr_q          <= 1'b0;
         abort_q       <= 1'b0;
         wdata_q       <= '0;
         drv_q         <= '0;
         bdal_out_q    <= '0;
         bdal_oe_q     <= '0;
         wr_ready_q    <= 1'b0;
         rd_data_q     <= '0;
         rd_valid_q    <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         err_timeout_q <= 1'b0;
         err_init_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         addr_q        <= addr_d;
         words_q       <= words_d;
         wr_q          <= wr_d;
         abort_q       <= abort_d;
         wdata_q       <= wdata_d;
         drv_q         <= drv_d;
         bdal_out_q    <= bdal_out_d;
         bdal_oe_q     <= bdal_oe_d;
         wr_ready_q    <= wr_ready_d;
         rd_data_q     <= rd_data_d;
         rd_valid_q    <= rd_valid_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         err_timeout_q <= err_timeout_d;
         err_init_q    <= err_init_d;
      end
   end

   assign bdmr_g      = drv_q.bdmr;
   assign bsack_g     = drv_q.bsack;
   assign bsync_g     = drv_q.bsync;
   assign bdin_g      = drv_q.bdin;
   assign bdout_g     = drv_q.bdout;
   assign bwtbt_g     = drv_q.bwtbt;
   assign bbs7_g      = drv_q.bbs7;
   assign outbound    = drv_q.outbound;
   assign bdal_out    = bdal_out_q;
   assign bdal_oe     = bdal_oe_q;
   assign wr_ready    = wr_ready_q;
   assign rd_data     = rd_data_q;
   assign rd_valid    = rd_valid_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err_timeout = err_timeout_q;
   assign err_init    = err_init_q;

endmodule

// File: tb/tb_qbus_dma_master.sv
// Directed bench for qbus_dma_master: the bench plays arbiter and slave.
module tb_qbus_dma_master;

   localparam int SETUP_CYC   = 15;
   localparam int TIMEOUT_CYC = 1000;

   localparam int S_BDMR  = 0;
   localparam int S_BSACK = 1;
   localparam int S_OUTB  = 2;
   localparam int S_BSYNC = 3;
   localparam int S_BDIN  = 4;
   localparam int S_BDOUT = 5;
   localparam int S_WRDY  = 6;
   localparam int S_DONE  = 7;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_start, cmd_write, abort;
   logic [21:0] cmd_addr;
   logic [7:0]  cmd_count;
   logic [15:0] wr_data;
   logic        wr_valid, wr_ready;
   logic [15:0] rd_data;
   logic        rd_valid, busy, done, err_timeout, err_init;
   logic [21:0] bdal_in_f;
   logic        bsync_f, brply_f, bdmgi_f, binit_f;
   logic [21:0] bdal_out, bdal_oe;
   logic        outbound, bdmr_g, bsack_g, bsync_g, bdin_g, bdout_g, bwtbt_g, bbs7_g;
   logic [7:0]  drives;

   int n_checks = 0;
   int n_errors = 0;
   int rd_cnt   = 0;
   int wr_cnt   = 0;

   qbus_dma_master dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_start   (cmd_start),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_count   (cmd_count),
      .abort       (abort),
      .wr_data     (wr_data),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .busy        (busy),
      .done        (done),
      .err_timeout (err_timeout),
      .err_init    (err_init),
      .bdal_in_f   (bdal_in_f),
      .bsync_f     (bsync_f),
      .brply_f     (brply_f),
      .bdmgi_f     (bdmgi_f),
      .binit_f     (binit_f),
      .bdal_out    (bdal_out),
      .bdal_oe     (bdal_oe),
      .outbound    (outbound),
      .bdmr_g      (bdmr_g),
      .bsack_g     (bsack_g),
      .bsync_g     (bsync_g),
      .bdin_g      (bdin_g),
      .bdout_g     (bdout_g),
      .bwtbt_g     (bwtbt_g),
      .bbs7_g      (bbs7_g)
   );

   assign drives = {bdmr_g, bsack_g, bsync_g, bdin_g, bdout_g, bwtbt_g, bbs7_g, outbound};

   always #5 clk = ~clk;

   // Pulse counters for the one-cycle host-side strobes.
   always @(posedge clk) begin
      if (rd_valid) rd_cnt <= rd_cnt + 1;
      if (wr_ready) wr_cnt <= wr_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic sig(input int idx);
      case (idx)
         S_BDMR:  return bdmr_g;
         S_BSACK: return bsack_g;
         S_OUTB:  return outbound;
         S_BSYNC: return bsync_g;
         S_BDIN:  return bdin_g;
         S_BDOUT: return bdout_g;
         S_WRDY:  return wr_ready;
         default: return done;
      endcase
   endfunction

   task automatic wait_for(input int idx, input logic lvl, input int limit, input string tag);
      int n = 0;
      while (sig(idx) !== lvl && n < limit) begin
         tick(1);
         n++;
      end
      check(tag, 32'(sig(idx)), 32'(lvl));
   endtask

   task automatic start_cmd(input logic w, input logic [21:0] a, input logic [7:0] c);
      cmd_write = w;
      cmd_addr  = a;
      cmd_count = c;
      cmd_start = 1'b1;
      tick(1);
      cmd_start = 1'b0;
   endtask

   task automatic grant(input int dly, input string tag);
      wait_for(S_BDMR, 1'b1, 10, {tag, "_bdmr"});
      tick(dly);
      bdmgi_f = 1'b0;
      wait_for(S_BSACK, 1'b1, 20, {tag, "_bsack"});
      bdmgi_f = 1'b1;
   endtask

   task automatic reply(input int strobe, input int dly, input string tag);
      wait_for(strobe, 1'b1, 100, {tag, "_strobe"});
      tick(dly);
      brply_f = 1'b0;
      wait_for(strobe, 1'b0, 50, {tag, "_negate"});
      brply_f = 1'b1;
   endtask

   initial begin
      int n;
      int rd0, wr0;
      reset     = 1'b1;
      cmd_start = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_count = '0;
      abort     = 1'b0;
      wr_data   = '0;
      wr_valid  = 1'b0;
      bdal_in_f = '1;
      bsync_f   = 1'b1;
      brply_f   = 1'b1;
      bdmgi_f   = 1'b1;
      binit_f   = 1'b1;

      // Reset state
      #3;
      check("rst_drives", 32'(drives), 32'h0);
      check("rst_oe", 32'(bdal_oe), 32'h0);
      check("rst_status", 32'({busy, done, err_timeout, err_init, wr_ready, rd_valid}), 32'h0);
      reset = 1'b0;
      tick(2);

      // Single read
      rd0 = rd_cnt;
      start_cmd(1'b0, 22'h001000, 8'd1);
      check("t1_busy", 32'(busy), 32'h1);
      grant(3, "t1_grant");
      wait_for(S_OUTB, 1'b1, 10, "t1_outbound");
      check("t1_addr", 32'(bdal_out), 32'h001000);
      check("t1_oe", 32'(bdal_oe), 32'h3FFFFF);
      check("t1_bbs7", 32'(bbs7_g), 32'h0);
      n = 0;
      while (!bsync_g && n < 50) begin
         tick(1);
         n++;
      end
      check("t1_setup", 32'(n), 32'(SETUP_CYC));
      bdal_in_f = {6'h3F, ~16'o123456};
      reply(S_BDIN, 20, "t1_reply");
      wait_for(S_BSACK, 1'b0, 50, "t1_bsack_fall");
      check("t1_done_early", 32'(done), 32'h0);
      tick(1);
      check("t1_done", 32'(done), 32'h1);
      check("t1_busy_clr", 32'(busy), 32'h0);
      check("t1_rd_data", 32'(rd_data), 32'o123456);
      check("t1_rd_pulses", 32'(rd_cnt - rd0), 32'h1);

      // Two-word write
      wr0      = wr_cnt;
      wr_data  = 16'hAAAA;
      wr_valid = 1'b1;
      start_cmd(1'b1, 22'h003FFE, 8'd2);
      grant(0, "t2_grant");
      wait_for(S_OUTB, 1'b1, 10, "t2_outbound0");
      check("t2_addr0", 32'(bdal_out), 32'h003FFE);
      check("t2_bwtbt0", 32'(bwtbt_g), 32'h1);
      wait_for(S_WRDY, 1'b1, 50, "t2_wr_ready0");
      check("t2_data0", 32'(bdal_out), 32'h00AAAA);
      wr_data = 16'h5555;
      reply(S_BDOUT, 10, "t2_reply0");
      wait_for(S_BSYNC, 1'b0, 50, "t2_end0");
      check("t2_bsack_mid", 32'(bsack_g), 32'h1);
      wait_for(S_OUTB, 1'b1, 30, "t2_outbound1");
      check("t2_addr1", 32'(bdal_out), 32'h004000);
      check("t2_bwtbt1", 32'(bwtbt_g), 32'h1);
      check("t2_bsack_w1", 32'(bsack_g), 32'h1);
      wait_for(S_WRDY, 1'b1, 50, "t2_wr_ready1");
      check("t2_data1", 32'(bdal_out), 32'h005555);
      wr_valid = 1'b0;
      reply(S_BDOUT, 10, "t2_reply1");
      wait_for(S_DONE, 1'b1, 100, "t2_done");
      check("t2_wr_pulses", 32'(wr_cnt - wr0), 32'h2);

      // Timeout: IO-page read with no slave
      rd0 = rd_cnt;
      start_cmd(1'b0, 22'h3FFF00, 8'd1);
      grant(2, "t3_grant");
      wait_for(S_OUTB, 1'b1, 10, "t3_outbound");
      check("t3_bbs7", 32'(bbs7_g), 32'h1);
      wait_for(S_BDIN, 1'b1, 100, "t3_bdin");
      n = 0;
      while (bdin_g && n < 1100) begin
         tick(1);
         n++;
      end
      check("t3_timeout_len", 32'(n >= TIMEOUT_CYC && n <= TIMEOUT_CYC + 2), 32'h1);
      wait_for(S_DONE, 1'b1, 100, "t3_done");
      check("t3_err_timeout", 32'(err_timeout), 32'h1);
      check("t3_no_rd_valid", 32'(rd_cnt - rd0), 32'h0);

      // Grant blocked by another master holding BSYNC
      bsync_f = 1'b0;
      start_cmd(1'b0, 22'h000100, 8'd1);
      check("t4_err_cleared", 32'(err_timeout), 32'h0);
      wait_for(S_BDMR, 1'b1, 10, "t4_bdmr");
      bdmgi_f = 1'b0;
      tick(10);
      check("t4_held_bsack", 32'(bsack_g), 32'h0);
      check("t4_held_bdmr", 32'(bdmr_g), 32'h1);
      bsync_f = 1'b1;
      n = 0;
      while (!bsack_g && n < 10) begin
         tick(1);
         n++;
      end
      check("t4_bsack_delay", 32'(n), 32'h3);
      bdmgi_f   = 1'b1;
      bdal_in_f = {6'h3F, ~16'h1234};
      reply(S_BDIN, 5, "t4_reply");
      wait_for(S_DONE, 1'b1, 100, "t4_done");
      check("t4_rd_data", 32'(rd_data), 32'h1234);

      // BINIT during a write
      wr_data  = 16'h1111;
      wr_valid = 1'b1;
      start_cmd(1'b1, 22'h000200, 8'd1);
      grant(1, "t5_grant");
      wait_for(S_BDOUT, 1'b1, 100, "t5_bdout");
      tick(2);
      binit_f = 1'b0;
      tick(3);
      check("t5_drives", 32'(drives), 32'h0);
      check("t5_oe", 32'(bdal_oe), 32'h0);
      check("t5_err_init", 32'(err_init), 32'h1);
      check("t5_done", 32'(done), 32'h1);
      check("t5_busy", 32'(busy), 32'h0);
      binit_f  = 1'b1;
      wr_valid = 1'b0;
      tick(4);

      // Abort while still requesting the bus
      start_cmd(1'b0, 22'h000010, 8'd4);
      wait_for(S_BDMR, 1'b1, 10, "t6_bdmr");
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      check("t6_drives", 32'(drives), 32'h0);
      tick(1);
      check("t6_done", 32'(done), 32'h1);
      check("t6_err_init_clr", 32'(err_init), 32'h0);

      // Reset mid-transfer with BSYNC asserted
      start_cmd(1'b0, 22'h000300, 8'd1);
      grant(1, "t7_grant");
      wait_for(S_BSYNC, 1'b1, 50, "t7_bsync");
      reset = 1'b1;
      #2;
      check("t7_drives", 32'(drives), 32'h0);
      check("t7_oe", 32'(bdal_oe), 32'h0);
      check("t7_busy", 32'(busy), 32'h0);
      reset = 1'b0;
      tick(2);
      check("t7_busy_after", 32'(busy), 32'h0);
      start_cmd(1'b0, 22'h000400, 8'd1);
      grant(3, "t7b_grant");
      bdal_in_f = {6'h3F, ~16'hBEEF};
      reply(S_BDIN, 4, "t7b_reply");
      wait_for(S_DONE, 1'b1, 100, "t7b_done");
      check("t7b_rd_data", 32'(rd_data), 32'hBEEF);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
